// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and data requesters
module mem_port_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int MAX_DM_RUN = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_ack_o,
    output logic              if_err_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ack_o,
    output logic              dm_err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    input  logic              mem_err_i,
    output logic [1:0]        grant_o
);

    localparam int RUN_W = $clog2(MAX_DM_RUN + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DM_RUN);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY, RESP} state_t;

    state_t           state;
    logic [RUN_W-1:0] run_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic             done;
    logic             fail;

    // A timeout with no ack is reported as an error, like an explicit mem_err_i.
    assign done = mem_ack_i || mem_err_i || (to_cnt == TO_LAST);
    assign fail = mem_err_i || !mem_ack_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            run_cnt     <= '0;
            to_cnt      <= '0;
            if_data_o   <= '0;
            if_ack_o    <= 1'b0;
            if_err_o    <= 1'b0;
            dm_rdata_o  <= '0;
            dm_ack_o    <= 1'b0;
            dm_err_o    <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            grant_o     <= 2'b00;
        end else begin
            if_ack_o   <= 1'b0;
            if_err_o   <= 1'b0;
            if_data_o  <= '0;
            dm_ack_o   <= 1'b0;
            dm_err_o   <= 1'b0;
            dm_rdata_o <= '0;
            case (state)
                IDLE: begin
                    if (dm_req_i && (!if_req_i || run_cnt < RUN_MAX)) begin
                        state       <= DM_BUSY;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= dm_we_i;
                        mem_addr_o  <= dm_addr_i;
                        mem_wdata_o <= dm_wdata_i;
                        grant_o     <= 2'b10;
                        to_cnt      <= '0;
                        // Only runs that keep fetch waiting count toward starvation.
                        if (!if_req_i)
                            run_cnt <= '0;
                        else if (run_cnt != RUN_MAX)
                            run_cnt <= run_cnt + 1'b1;
                    end else if (if_req_i) begin
                        state       <= IF_BUSY;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= 1'b0;
                        mem_addr_o  <= if_addr_i;
                        mem_wdata_o <= '0;
                        grant_o     <= 2'b01;
                        to_cnt      <= '0;
                        run_cnt     <= '0;
                    end
                end
                IF_BUSY, DM_BUSY: begin
                    if (done) begin
                        state       <= RESP;
                        mem_req_o   <= 1'b0;
                        mem_we_o    <= 1'b0;
                        mem_addr_o  <= '0;
                        mem_wdata_o <= '0;
                        grant_o     <= 2'b00;
                        to_cnt      <= '0;
                        if (state == IF_BUSY) begin
                            if_ack_o  <= !fail;
                            if_err_o  <= fail;
                            if_data_o <= fail ? '0 : mem_rdata_i;
                        end else begin
                            dm_ack_o   <= !fail;
                            dm_err_o   <= fail;
                            dm_rdata_o <= (fail || mem_we_o) ? '0 : mem_rdata_i;
                        end
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [63:0] if_addr = '0;
    logic [63:0] if_data;
    logic        if_ack, if_err;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [63:0] dm_addr = '0;
    logic [63:0] dm_wdata = '0;
    logic [63:0] dm_rdata;
    logic        dm_ack, dm_err;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [63:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        mem_err = 1'b0;
    logic [1:0]  grant;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter dut (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_data_o(if_data),
        .if_ack_o(if_ack), .if_err_o(if_err),
        .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr),
        .dm_wdata_i(dm_wdata), .dm_rdata_o(dm_rdata),
        .dm_ack_o(dm_ack), .dm_err_o(dm_err),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
        .mem_ack_i(mem_ack), .mem_err_i(mem_err), .grant_o(grant)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!mem_req && n < 20) begin
            tick();
            n++;
        end
        check("req_seen", mem_req, 1);
    endtask

    // Hold the response off for lat cycles, then complete; leaves us in the RESP cycle.
    task automatic serve(input int lat, input logic err, input logic [63:0] rdata);
        for (int i = 0; i < lat; i++) begin
            check("req_hold", mem_req, 1);
            tick();
        end
        check("req_hold", mem_req, 1);
        mem_ack = 1'b1;
        mem_err = err;
        mem_rdata = rdata;
        tick();
        mem_ack = 1'b0;
        mem_err = 1'b0;
        mem_rdata = '0;
        check("req_drop", mem_req, 0);
        check("grant_none", grant, 0);
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        check("rst_req", mem_req, 0);
        check("rst_grant", grant, 0);
        check("rst_acks", {if_ack, if_err, dm_ack, dm_err}, 0);

        // single fetch
        if_req = 1'b1; if_addr = 64'h100;
        tick();
        check("f_req", mem_req, 1);
        check("f_addr", mem_addr, 64'h100);
        check("f_we", mem_we, 0);
        check("f_grant", grant, 1);
        serve(2, 1'b0, 64'h3056);
        check("f_ack", if_ack, 1);
        check("f_data", if_data, 64'h3056);
        if_req = 1'b0;
        tick();
        check("f_ack_off", if_ack, 0);
        check("f_data_off", if_data, 0);

        // simultaneous: DM write wins, then IF
        if_req = 1'b1; if_addr = 64'h200;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 64'h40; dm_wdata = 64'h2;
        tick();
        check("s_grant_dm", grant, 2);
        check("s_we", mem_we, 1);
        check("s_addr", mem_addr, 64'h40);
        check("s_wdata", mem_wdata, 64'h2);
        serve(0, 1'b0, 64'hdead);
        check("s_dm_ack", dm_ack, 1);
        check("s_dm_rdata", dm_rdata, 0);
        check("s_if_ack", if_ack, 0);
        dm_req = 1'b0;
        wait_req();
        check("s_grant_if", grant, 1);
        check("s_if_addr", mem_addr, 64'h200);
        check("s_if_wdata", mem_wdata, 0);
        serve(0, 1'b0, 64'h77);
        check("s_if_ack2", if_ack, 1);
        check("s_if_data", if_data, 64'h77);

        // starvation guard: DM x4, IF x1, repeat
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h300;
        for (int k = 0; k < 10; k++) begin
            wait_req();
            check("st_grant", grant, (k % 5 == 4) ? 2'd1 : 2'd2);
            serve(0, 1'b0, 64'(k + 1));
            check("st_ack", {if_ack, dm_ack}, (k % 5 == 4) ? 2'b10 : 2'b01);
        end
        if_req = 1'b0; dm_req = 1'b0;
        tick();
        tick();

        // timeout on DM read
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h80;
        wait_req();
        check("t_addr", mem_addr, 64'h80);
        for (int i = 0; i < 15; i++) begin
            check("t_req_hold", mem_req, 1);
            tick();
        end
        check("t_req_drop", mem_req, 0);
        check("t_err", dm_err, 1);
        check("t_ack", dm_ack, 0);
        dm_req = 1'b0;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("t_late_ack", {dm_ack, dm_err, if_ack, if_err}, 0);
        tick();
        check("t_idle", mem_req, 0);

        // memory error wins over ack
        if_req = 1'b1; if_addr = 64'h400;
        wait_req();
        serve(1, 1'b1, 64'h55);
        check("e_err", if_err, 1);
        check("e_ack", if_ack, 0);
        check("e_data", if_data, 0);
        if_req = 1'b0;
        tick();
        check("e_err_off", if_err, 0);

        // reset during DM_BUSY
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 64'h500; dm_wdata = 64'h9;
        wait_req();
        tick();
        rst = 1'b1;
        mem_ack = 1'b1;
        tick();
        rst = 1'b0;
        mem_ack = 1'b0;
        check("r_req", mem_req, 0);
        check("r_grant", grant, 0);
        check("r_acks", {dm_ack, dm_err, if_ack, if_err}, 0);
        check("r_addr", mem_addr, 0);
        wait_req();
        check("r2_addr", mem_addr, 64'h500);
        check("r2_wdata", mem_wdata, 64'h9);
        serve(1, 1'b0, 64'h0);
        check("r2_ack", dm_ack, 1);
        dm_req = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
